// File: rtl/move_executor_if.sv
// Move request/completion channel between a move source (master) and move_executor (slave).
interface move_executor_if #(
  parameter int NUM_AXES = 6
);
  localparam int FW = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;

  logic          move_valid;
  logic          move_ready;
  logic [FW-1:0] move_face;
  logic          move_dir;
  logic          move_half;
  logic          move_done;
  logic [1:0]    move_status;

  modport master (
    output move_valid, move_face, move_dir, move_half,
    input  move_ready, move_done, move_status
  );

  modport slave (
    input  move_valid, move_face, move_dir, move_half,
    output move_ready, move_done, move_status
  );
endinterface

// File: rtl/move_executor.sv
// Executes one quarter/half turn on a stepper face: dir setup, step pulses, settle, one-cycle done; accepts only when idle.
// Optional macro MOVE_ACCEL_EN: the first and last ramp steps run at double phase length.
module move_executor #(
  parameter int NUM_AXES      = 6,
  parameter int QUARTER_STEPS = 50,
  parameter int HALF_PERIOD   = 31250,
  parameter int DIR_SETUP     = 100,
  parameter int SETTLE        = 400,
  parameter int RAMP_STEPS    = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                disable_steppers,
  move_executor_if.slave      mv,
  output logic                step_pin,
  output logic                dir_pin,
  output logic [NUM_AXES-1:0] en_pins,
  output logic                busy
);

`ifdef MOVE_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  localparam int RAMP_MAX = ACCEL ? RAMP_STEPS : 0;
  localparam int PH_SLOW  = ACCEL ? 2 * HALF_PERIOD : HALF_PERIOD;
  localparam int MAXL_A   = (DIR_SETUP > SETTLE) ? DIR_SETUP : SETTLE;
  localparam int MAXL     = (MAXL_A > PH_SLOW) ? MAXL_A : PH_SLOW;
  localparam int CW       = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam int SW       = $clog2(2 * QUARTER_STEPS + 1);

  localparam logic [NUM_AXES-1:0] EN_ONE     = NUM_AXES'(1);
  localparam logic [1:0]          STAT_OK    = 2'b00;
  localparam logic [1:0]          STAT_BAD   = 2'b01;
  localparam logic [1:0]          STAT_ABORT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STEP_HI, ST_STEP_LO, ST_SETTLE, ST_DONE
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [SW-1:0]       rem_q;
  logic                half_q;
  logic                step_q;
  logic                dir_q;
  logic [NUM_AXES-1:0] en_q;
  logic                done_q;
  logic [1:0]          status_q;
  logic                busy_q;

  logic          ready;
  logic          face_bad;
  logic [CW-1:0] len_cur_d;
  logic [CW-1:0] len_next_d;
  int            n_steps;
  int            ramp;
  int            rem_i;

  assign ready    = (state_q == ST_IDLE) && !disable_steppers && reset_n;
  assign face_bad = 32'(mv.move_face) >= NUM_AXES;

  // Phase length (minus one) of the current step and of the step after it; rem counts down from n_steps to 1.
  always_comb begin
    n_steps    = half_q ? 2 * QUARTER_STEPS : QUARTER_STEPS;
    ramp       = (RAMP_MAX < n_steps / 2) ? RAMP_MAX : n_steps / 2;
    rem_i      = int'(rem_q);
    len_cur_d  = ((rem_i > n_steps - ramp) || (rem_i <= ramp))
               ? CW'(PH_SLOW - 1) : CW'(HALF_PERIOD - 1);
    len_next_d = ((rem_i - 1 > n_steps - ramp) || (rem_i - 1 <= ramp))
               ? CW'(PH_SLOW - 1) : CW'(HALF_PERIOD - 1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      half_q   <= 1'b0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      en_q     <= '0;
      done_q   <= 1'b0;
      status_q <= STAT_OK;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mv.move_valid && ready) begin
            dir_q  <= mv.move_dir;
            half_q <= mv.move_half;
            busy_q <= 1'b1;
            rem_q  <= mv.move_half ? SW'(2 * QUARTER_STEPS) : SW'(QUARTER_STEPS);
            if (face_bad) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              status_q <= STAT_BAD;
            end else begin
              state_q <= ST_SETUP;
              en_q    <= EN_ONE << mv.move_face;
              cnt_q   <= CW'(DIR_SETUP - 1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          if (disable_steppers) begin
            state_q  <= ST_DONE;
            step_q   <= 1'b0;
            en_q     <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b1;
            status_q <= STAT_ABORT;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            case (state_q)
              ST_SETUP: begin
                state_q <= ST_STEP_HI;
                step_q  <= 1'b1;
                cnt_q   <= len_cur_d;
              end
              ST_STEP_HI: begin
                state_q <= ST_STEP_LO;
                step_q  <= 1'b0;
                cnt_q   <= len_cur_d;
              end
              ST_STEP_LO: begin
                if (rem_q == SW'(1)) begin
                  state_q <= ST_SETTLE;
                  cnt_q   <= CW'(SETTLE - 1);
                end else begin
                  rem_q   <= rem_q - 1'b1;
                  state_q <= ST_STEP_HI;
                  step_q  <= 1'b1;
                  cnt_q   <= len_next_d;
                end
              end
              ST_SETTLE: begin
                state_q  <= ST_DONE;
                en_q     <= '0;
                done_q   <= 1'b1;
                status_q <= STAT_OK;
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign mv.move_ready  = ready;
  assign mv.move_done   = done_q;
  assign mv.move_status = status_q;
  assign step_pin       = step_q;
  assign dir_pin        = dir_q;
  assign en_pins        = en_q;
  assign busy           = busy_q;

endmodule
